// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS data-bus sniffer.
//   bus_rec_t : one captured bus transaction {kind, addr, data} (65 bits)
//   KIND_*    : encoding of bus_rec_t.kind
//   DROP_W    : width of the saturating drop counter
package mips_dbg_pkg;

  localparam logic KIND_LOAD  = 1'b0;
  localparam logic KIND_STORE = 1'b1;
  localparam int   DROP_W     = 16;

  typedef struct packed {
    logic        kind;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_push, i_din   write request and element
//   i_pop           read request (head is consumed at the edge)
//   o_dout          head element, zero while empty
//   o_full, o_empty occupancy flags
//   o_count         explicit occupancy, 0..DEPTH
// A push into a full FIFO is accepted only when a pop happens in the
// same cycle; otherwise it is ignored (the caller accounts for drops).
module sync_fifo
  import mips_dbg_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = bus_rec_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  T                         i_din,
  input  logic                     i_pop,
  output T                         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Zero the head while empty so the outputs have a defined reset value
  // without resetting the storage array.
  always_comb begin
    o_dout = '0;
    if (!o_empty) o_dout = r_mem[r_rptr];
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mips_bus_sniffer.sv
// Passive observer of the MIPS data-memory interface. Stores (and loads
// when CAPTURE_LOADS=1) inside [ADDR_LO, ADDR_HI] are queued in a FIFO and
// streamed out on a valid/ready record port.
// Ports:
//   clk, rst                       clock, async active-high reset
//   mem_write, mem_read            MIPS data-memory strobes
//   direccion, palabra, leer_dato  address, store data, load data
//   rec_valid/rec_ready            record stream handshake
//   rec_kind/rec_addr/rec_data     head record (kind 1 = store)
//   fifo_count                     FIFO occupancy
//   drop_count, overflow           saturating drop counter, sticky flag
//   proto_err                      sticky: write and read in one cycle
//   clr_stats                      sync clear of drop_count/overflow/proto_err
module mips_bus_sniffer
  import mips_dbg_pkg::*;
#(
  parameter int          DEPTH         = 8,
  parameter logic [31:0] ADDR_LO       = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI       = 32'hFFFF_FFFF,
  parameter bit          CAPTURE_LOADS = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_write,
  input  logic                    mem_read,
  input  logic [31:0]             direccion,
  input  logic [31:0]             palabra,
  input  logic [31:0]             leer_dato,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic                    rec_kind,
  output logic [31:0]             rec_addr,
  output logic [31:0]             rec_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [DROP_W-1:0]       drop_count,
  output logic                    overflow,
  output logic                    proto_err,
  input  logic                    clr_stats
);

  logic [32:0] w_lo_diff;
  logic [32:0] w_hi_diff;
  logic        w_in_win;
  logic        w_hit_w;
  logic        w_hit_r;
  logic        w_hit;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_drop;
  bus_rec_t    w_rec;
  bus_rec_t    w_head;

  // Window bounds checked via 33-bit borrow so a bound at 0 or FFFF_FFFF
  // does not collapse into a constant comparison.
  assign w_lo_diff = {1'b0, direccion} - {1'b0, ADDR_LO};
  assign w_hi_diff = {1'b0, ADDR_HI}   - {1'b0, direccion};
  assign w_in_win  = !w_lo_diff[32] && !w_hi_diff[32];

  // A simultaneous read is ignored in favour of the store.
  assign w_hit_w = mem_write && w_in_win;
  assign w_hit_r = mem_read && !mem_write && CAPTURE_LOADS && w_in_win;
  assign w_hit   = w_hit_w || w_hit_r;

  assign w_rec.kind = w_hit_w ? KIND_STORE : KIND_LOAD;
  assign w_rec.addr = direccion;
  assign w_rec.data = w_hit_w ? palabra : leer_dato;

  assign w_pop  = rec_valid && rec_ready;
  assign w_drop = w_hit && w_full && !w_pop;

  sync_fifo #(.DEPTH(DEPTH), .T(bus_rec_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_hit),
    .i_din   (w_rec),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign rec_valid = !w_empty;
  assign rec_kind  = w_head.kind;
  assign rec_addr  = w_head.addr;
  assign rec_data  = w_head.data;

  // Clear has priority over a drop or conflict in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
    end else if (clr_stats) begin
      drop_count <= '0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
      if (mem_write && mem_read) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_bus_sniffer.sv
module tb_mips_bus_sniffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] direccion = '0;
  logic [31:0] palabra = '0;
  logic [31:0] leer_dato = '0;
  logic        rec_ready = 1'b0;
  logic        clr_stats = 1'b0;

  logic        rec_valid, rec_kind, overflow, proto_err;
  logic [31:0] rec_addr, rec_data;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;

  logic        n_valid, n_kind, n_ovf, n_perr;
  logic [31:0] n_addr, n_data;
  logic [3:0]  n_count;
  logic [15:0] n_drop;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mips_bus_sniffer #(.DEPTH(8), .ADDR_LO(32'h10), .ADDR_HI(32'h1F), .CAPTURE_LOADS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_read(mem_read),
    .direccion(direccion), .palabra(palabra), .leer_dato(leer_dato),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_addr(rec_addr), .rec_data(rec_data), .fifo_count(fifo_count),
    .drop_count(drop_count), .overflow(overflow), .proto_err(proto_err),
    .clr_stats(clr_stats)
  );

  // Same window, loads not captured.
  mips_bus_sniffer #(.DEPTH(8), .ADDR_LO(32'h10), .ADDR_HI(32'h1F), .CAPTURE_LOADS(1'b0)) u_nold (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_read(mem_read),
    .direccion(direccion), .palabra(palabra), .leer_dato(leer_dato),
    .rec_valid(n_valid), .rec_ready(rec_ready), .rec_kind(n_kind),
    .rec_addr(n_addr), .rec_data(n_data), .fifo_count(n_count),
    .drop_count(n_drop), .overflow(n_ovf), .proto_err(n_perr),
    .clr_stats(clr_stats)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; direccion = a; palabra = d;
    step();
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", rec_valid); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    total++; if ({rec_kind, rec_addr, rec_data} !== 65'd0) begin bad++; $display("FAIL rst_rec got=%0h exp=0", {rec_kind, rec_addr, rec_data}); end
    total++; if ({drop_count, overflow, proto_err} !== 18'd0) begin bad++; $display("FAIL rst_stats got=%0h exp=0", {drop_count, overflow, proto_err}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_store();
    store(32'h14, 32'hDEADBEEF);
    total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL store_valid got=%0h exp=1", rec_valid); end
    total++; if (rec_kind !== 1'b1) begin bad++; $display("FAIL store_kind got=%0h exp=1", rec_kind); end
    total++; if (rec_addr !== 32'h14) begin bad++; $display("FAIL store_addr got=%0h exp=14", rec_addr); end
    total++; if (rec_data !== 32'hDEADBEEF) begin bad++; $display("FAIL store_data got=%0h exp=deadbeef", rec_data); end
    total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL store_count got=%0d exp=1", fifo_count); end
    step();
    total++; if (rec_data !== 32'hDEADBEEF) begin bad++; $display("FAIL store_hold got=%0h exp=deadbeef", rec_data); end
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
    total++; if (fifo_count !== 4'd0 || rec_valid !== 1'b0) begin bad++; $display("FAIL store_pop got=%0d/%0h exp=0/0", fifo_count, rec_valid); end
    // Empty FIFO, hit with ready already high: no bypass, record shows next cycle.
    rec_ready = 1'b1;
    store(32'h10, 32'h0000_1234);
    total++; if (rec_valid !== 1'b1 || rec_data !== 32'h1234) begin bad++; $display("FAIL nobypass got=%0h/%0h exp=1/1234", rec_valid, rec_data); end
    step(); rec_ready = 1'b0;
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL nobypass_pop got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_load_filter();
    mem_read = 1'b1; direccion = 32'h20; leer_dato = 32'h55;
    step();
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL load_outwin got=%0d exp=0", fifo_count); end
    direccion = 32'h1C;
    step();
    mem_read = 1'b0;
    total++; if (rec_valid !== 1'b1 || rec_kind !== 1'b0) begin bad++; $display("FAIL load_kind got=%0h/%0h exp=1/0", rec_valid, rec_kind); end
    total++; if (rec_data !== 32'h55 || rec_addr !== 32'h1C) begin bad++; $display("FAIL load_rec got=%0h/%0h exp=55/1c", rec_data, rec_addr); end
    total++; if (n_count !== 4'd0 || n_valid !== 1'b0) begin bad++; $display("FAIL load_nocap got=%0d/%0h exp=0/0", n_count, n_valid); end
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) begin
      mem_write = 1'b1; direccion = 32'h10 + i; palabra = i;
      step();
    end
    mem_write = 1'b0;
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
    total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (rec_valid !== 1'b1 || rec_data !== i) begin bad++; $display("FAIL ovf_drain%0d got=%0h exp=%0h", i, rec_data, i); end
      rec_ready = 1'b1; step(); rec_ready = 1'b0;
    end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL ovf_empty got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_conflict_clear();
    mem_write = 1'b1; mem_read = 1'b1; direccion = 32'h18; palabra = 32'h1; leer_dato = 32'h2;
    step();
    mem_write = 1'b0; mem_read = 1'b0;
    total++; if (fifo_count !== 4'd1 || rec_kind !== 1'b1 || rec_data !== 32'h1) begin bad++; $display("FAIL conf_rec got=%0d/%0h/%0h exp=1/1/1", fifo_count, rec_kind, rec_data); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL conf_perr got=%0h exp=1", proto_err); end
    total++; if (drop_count !== 16'd2 || overflow !== 1'b1) begin bad++; $display("FAIL conf_sticky got=%0d/%0h exp=2/1", drop_count, overflow); end
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    total++; if ({drop_count, overflow, proto_err} !== 18'd0) begin bad++; $display("FAIL clr_stats got=%0h exp=0", {drop_count, overflow, proto_err}); end
    total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL clr_fifo got=%0d exp=1", fifo_count); end
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) store(32'h10, 32'h100 + i);
    // Drop and clear in the same cycle: clear wins.
    clr_stats = 1'b1;
    store(32'h11, 32'hBB);
    clr_stats = 1'b0;
    total++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin bad++; $display("FAIL clrwin got=%0d/%0h exp=0/0", drop_count, overflow); end
    rec_ready = 1'b1;
    store(32'h12, 32'hAA);
    rec_ready = 1'b0;
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL pp_count got=%0d exp=8", fifo_count); end
    total++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin bad++; $display("FAIL pp_drop got=%0d/%0h exp=0/0", drop_count, overflow); end
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] exp_d;
      exp_d = (i == 8) ? 32'hAA : 32'h100 + i;
      total++; if (rec_data !== exp_d) begin bad++; $display("FAIL pp_drain%0d got=%0h exp=%0h", i, rec_data, exp_d); end
      rec_ready = 1'b1; step(); rec_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) store(32'h13, 32'h300 + i);
    total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL mid_pre got=%0d exp=3", fifo_count); end
    #2 rst = 1'b1;
    #1;
    total++; if (rec_valid !== 1'b0 || fifo_count !== 4'd0) begin bad++; $display("FAIL mid_rst got=%0h/%0d exp=0/0", rec_valid, fifo_count); end
    total++; if (rec_data !== 32'd0) begin bad++; $display("FAIL mid_rst_data got=%0h exp=0", rec_data); end
    step();
    #2 rst = 1'b0;
    step();
    store(32'h1A, 32'h77);
    total++; if (rec_addr !== 32'h1A || rec_data !== 32'h77 || fifo_count !== 4'd1) begin bad++; $display("FAIL mid_after got=%0h/%0h/%0d exp=1a/77/1", rec_addr, rec_data, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_filter();
    test_overflow();
    test_conflict_clear();
    test_full_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_bus_sniffer.md
Name: mips_bus_sniffer

Overview:
- Passive observer on the MIPS data-memory interface (direccion, palabra, leer_dato).
- Captures store transactions, and optionally load transactions, whose address falls in a configured window.
- Queues captured transactions in a FIFO and presents them on a valid/ready stream to a downstream logger or debug port.
- Counts dropped transactions, so a bench or board-level debug path can check the CPU's memory traffic without probing internal MIPS nets.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ADDR_LO, 32'h0000_0000, inclusive lower bound of the capture window.
- ADDR_HI, 32'hFFFF_FFFF, inclusive upper bound of the capture window; must be at least ADDR_LO.
- CAPTURE_LOADS, 1, when 1 loads are also captured; when 0 only stores are captured.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_write  in  1  MIPS data-memory write strobe.
- mem_read  in  1  MIPS data-memory read strobe.
- direccion  in  32  data-memory address from the MIPS.
- palabra  in  32  store data from the MIPS.
- leer_dato  in  32  load data returned to the MIPS; combinational in the same cycle as direccion.
- rec_valid  out  1  a record is available at the FIFO head.
- rec_ready  in  1  the consumer accepts the head record.
- rec_kind  out  1  record type: 1 = store, 0 = load.
- rec_addr  out  32  captured address.
- rec_data  out  32  captured palabra (store) or leer_dato (load).
- fifo_count  out  $clog2(DEPTH)+1  current number of occupied entries.
- drop_count  out  16  number of dropped records; saturates at 16'hFFFF.
- overflow  out  1  sticky flag, set on the first drop.
- proto_err  out  1  sticky flag, set when mem_write and mem_read are asserted in the same cycle.
- clr_stats  in  1  synchronous clear of drop_count, overflow and proto_err.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO emptied; read and write pointers = 0; fifo_count = 0.
  - rec_valid = 0; rec_kind = 0; rec_addr = 0; rec_data = 0.
  - drop_count = 0; overflow = 0; proto_err = 0.
- Hit condition, evaluated per rising edge:
  - in_win = (direccion >= ADDR_LO) && (direccion <= ADDR_HI), unsigned 32-bit compare.
  - hit_w = mem_write && in_win.
  - hit_r = mem_read && !mem_write && CAPTURE_LOADS && in_win.
- Simultaneous mem_write and mem_read:
  - The store is captured and the load is ignored.
  - proto_err is set regardless of in_win.
- Push on a hit: record = {kind, direccion, hit_w ? palabra : leer_dato}, sampled at that edge.
- Pop when rec_valid && rec_ready.
- FIFO head is first-word-fall-through:
  - rec_* show the head entry.
  - A record pushed at edge N appears with rec_valid = 1 after edge N, giving 1-cycle latency into an empty FIFO.
- Full FIFO with a hit:
  - With a pop in the same cycle: push and pop both occur; count unchanged; nothing is dropped.
  - With no pop in the same cycle: the record is discarded, drop_count is incremented (saturating at FFFF), and overflow is set.
- Empty FIFO with a hit and rec_ready = 1: no bypass; the record appears the next cycle.
- rec_* must hold stable while rec_valid = 1 and rec_ready = 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count is the explicit occupancy, updated as +1 on push only, -1 on pop only, and unchanged on both or neither.
- clr_stats:
  - Takes effect at the edge.
  - If a drop occurs in the same cycle, the clear wins, so drop_count = 0 and overflow = 0.
  - Does not affect FIFO contents.
- The block never drives MIPS signals and has no back-pressure on the CPU.

Decomposition:
- Package mips_dbg_pkg holds:
  - typedef bus_rec_t (packed struct: kind, addr[31:0], data[31:0], 65 bits);
  - constants KIND_LOAD = 1'b0 and KIND_STORE = 1'b1;
  - DROP_W = 16.
- One sub-module, sync_fifo (parameterised DEPTH, element type bus_rec_t), containing the storage, pointers, count, full and empty.
- The top level contains the window compare, hit logic, statistics counters and sticky flags.

Test Plan:
- Store in window: ADDR_LO = 0x10, ADDR_HI = 0x1F; mem_write = 1, direccion = 0x14, palabra = 0xDEADBEEF for one cycle -> next cycle rec_valid = 1, rec_kind = 1, rec_addr = 0x14, rec_data = 0xDEADBEEF, fifo_count = 1; rec_ready pulse -> fifo_count = 0.
- Load filtering: mem_read = 1, direccion = 0x20, leer_dato = 0x55 (out of window) -> no record. Then direccion = 0x1C with CAPTURE_LOADS = 1 -> record kind = 0, rec_data = 0x55; with CAPTURE_LOADS = 0 -> no record.
- Overflow: DEPTH = 8, rec_ready = 0, 10 consecutive in-window stores with palabra = 1..10 -> fifo_count = 8, drop_count = 2, overflow = 1; draining yields data 1..8 in order.
- Full with simultaneous push and pop: FIFO full, rec_ready = 1 and a store with palabra = 0xAA in the same cycle -> no drop, fifo_count stays 8, and 0xAA is the last record drained.
- Conflict and clear: mem_write = mem_read = 1 at 0x18, palabra = 0x1, leer_dato = 0x2 -> one store record with data 0x1 and proto_err = 1; clr_stats pulse -> proto_err = 0, drop_count = 0.
- Reset mid-operation: 3 queued records, rst asserted between clock edges -> immediately rec_valid = 0 and fifo_count = 0; after release the first new store is the head record.
